riscv_axi_rd_arb: RTL and testbench
===================================

# riscv_axi_rd_arb

Two-to-one AXI4 read-channel arbiter. It shares the single external AR/R master port between the instruction fetch unit (requester 1) and the load/store unit (requester 0). Sits in `riscv_top` between the requesters' AR/R ports and the top-level `AXI_AR_M`/`AXI_R_S` bus. At most one burst is in flight at a time, so R-channel routing never needs ID lookup.

## Interface
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 means requester 1 (IFU) always wins ties.
- `ACLK`  in  1  clock, taken from `AXI_COMMON.ACLK`.
- `ARESETn`  in  1  asynchronous, active-low reset, taken from `AXI_COMMON.ARESETn`.
- `REQ_AR_M`  in  `axi4_pkg::ar_m [1:0]`  requester address requests (ARVALID, ARADDR, ARLEN, ARID, …).
- `REQ_AR_S`  out  `axi4_pkg::ar_s [1:0]`  ARREADY back to each requester.
- `REQ_R_M`  in  `axi4_pkg::r_m [1:0]`  RREADY from each requester.
- `REQ_R_S`  out  `axi4_pkg::r_s [1:0]`  routed read data/response to each requester.
- `BUS_AR_M`  out  `axi4_pkg::ar_m`  address request to the bus.
- `BUS_AR_S`  in  `axi4_pkg::ar_s`  bus ARREADY.
- `BUS_R_M`  out  `axi4_pkg::r_m`  RREADY to the bus.
- `BUS_R_S`  in  `axi4_pkg::r_s`  bus read data/response.
- `PROTO_ERR`  out  1  sticky flag: RLAST beat count disagreed with the captured ARLEN. Cleared only by reset.

## Operation
- FSM states: IDLE, ADDR, DATA.
- **IDLE**
  - No requester ARVALID: stay in IDLE.
  - One requester ARVALID: grant it.
  - Both ARVALID: grant `~last_grant` in round-robin mode, or requester 1 when `FIXED_PRIO=1`.
  - On grant: assert `REQ_AR_S[g].ARREADY` in the same cycle (combinational).
  - Capture the full `ar_m` payload into `ar_q`, store `g` in `grant_q`, store ARLEN in `len_q`, update `last_grant`, go to ADDR.
- **ADDR**
  - `BUS_AR_M` = `ar_q` with ARVALID=1.
  - Payload stays stable until `BUS_AR_S.ARREADY`, then go to DATA.
  - `REQ_AR_S[*].ARREADY` = 0.
- **DATA**
  - `REQ_R_S[grant_q]` = `BUS_R_S`. The other requester gets all-zero `r_s` (RVALID=0).
  - `BUS_R_M.RREADY` = `REQ_R_M[grant_q].RREADY`.
  - Beat counter `beat_q` (width of ARLEN + 1) increments on each RVALID&RREADY handshake.
  - On the RLAST handshake:
    - If `beat_q != len_q`, set `PROTO_ERR`.
    - Clear `beat_q` and go to IDLE.
  - A non-RLAST handshake with `beat_q == len_q` also sets `PROTO_ERR`. The FSM keeps waiting for RLAST.
- Outside DATA, `BUS_R_M.RREADY` = 0 and `REQ_R_S[*].RVALID` = 0.
- Reset (asynchronous, any state, including mid-burst):
  - FSM goes to IDLE.
  - `ar_q`, `grant_q`, `len_q`, `beat_q`, `PROTO_ERR` go to 0; `last_grant` goes to 1, so requester 0 wins the first round-robin tie.
  - All outputs are 0: every VALID/READY low, payloads zero.
- Requester ARVALID held across ADDR/DATA: it is not accepted until the FSM returns to IDLE. It may then win that IDLE cycle.

## Timing
- Requester ARVALID seen in IDLE at cycle N: ARREADY at N, `BUS_AR_M.ARVALID` from N+1.
- Bus ARREADY at cycle M: DATA from M+1. The first R beat can be forwarded at M+1.
- R path is combinational (zero added latency), both data and RREADY.
- Final RLAST handshake at cycle K: IDLE at K+1, next grant no earlier than K+1.
- Minimum burst-to-burst spacing: 3 cycles for single-beat reads with bus ARREADY and RVALID already high.
- All registers sit on the `ACLK` rising edge, with asynchronous clear on `ARESETn` low.

## Structure
- `axi4_pkg` already holds the `ar_m`/`ar_s`/`r_m`/`r_s` types.
- Add `arb_state_e` (IDLE/ADDR/DATA) to a new `riscv_pkg`, along with the constants `REQ_LSU=0` and `REQ_IFU=1`.
- One natural sub-module: `riscv_rr_arb2`. It is the combinational 2-way grant logic, taking the request vector, `last_grant` and `FIXED_PRIO`, and returning a one-hot grant.
- `riscv_top` instantiates this block between `ifu`/LSU and `AXI_AR_M[1]`/`AXI_R_S[1]`.

## Test plan
- Reset mid-DATA (ARLEN=3, after 2 beats), ARESETn low for 1 cycle → all outputs 0 the same cycle, FSM in IDLE, `PROTO_ERR`=0.
- Single IFU request ARADDR=0x100, ARLEN=0, bus ARREADY immediate, RDATA=0xDEADBEEF with RLAST → IFU ARREADY at N, bus ARVALID at N+1, IFU receives 0xDEADBEEF, LSU RVALID stays 0.
- Both requesters hold ARVALID continuously, round-robin, 4 single-beat bursts → grant order 0,1,0,1. With `FIXED_PRIO=1` → 1,1,1,1.
- Bus ARREADY delayed 5 cycles while ARADDR on the requester side changes → `BUS_AR_M` payload stays stable at the captured value the whole time.
- Requester RREADY toggling during a 4-beat burst (ARLEN=3) → `BUS_R_M.RREADY` mirrors it exactly, 4 handshakes, back to IDLE the cycle after RLAST, `PROTO_ERR`=0.
- RLAST delivered on beat 2 of an ARLEN=3 burst → `PROTO_ERR`=1 the next cycle, FSM returns to IDLE, and the flag stays set until reset.

Source files
------------

// File: rtl/axi4_pkg.sv
// axi4_pkg: AXI4 read-channel (AR/R) payload types shared by the bus masters and slaves.
package axi4_pkg;
    typedef struct packed {
        logic        ARVALID;
        logic [31:0] ARADDR;
        logic [7:0]  ARLEN;
        logic [2:0]  ARSIZE;
        logic [1:0]  ARBURST;
        logic [3:0]  ARID;
    } ar_m;
    typedef struct packed {
        logic ARREADY;
    } ar_s;
    typedef struct packed {
        logic RREADY;
    } r_m;
    typedef struct packed {
        logic        RVALID;
        logic [31:0] RDATA;
        logic [1:0]  RRESP;
        logic        RLAST;
        logic [3:0]  RID;
    } r_s;
endpackage

// File: rtl/riscv_pkg.sv
// riscv_pkg: core-wide constants and the read arbiter state encoding.
package riscv_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e;
    localparam logic REQ_LSU = 1'b0;
    localparam logic REQ_IFU = 1'b1;
endpackage

// File: rtl/riscv_rr_arb2.sv
// riscv_rr_arb2: combinational two-way grant, round-robin or IFU-priority on ties.
module riscv_rr_arb2 import riscv_pkg::*; #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);
    logic win;
    always_comb begin
        win = req[REQ_IFU] ? REQ_IFU : REQ_LSU;
        if (&req) win = FIXED_PRIO ? REQ_IFU : ~last_grant;
        gnt = |req ? (2'b01 << win) : 2'b00;
    end
endmodule

// File: rtl/riscv_axi_rd_arb.sv
// riscv_axi_rd_arb: shares one AXI4 AR/R master port between LSU (0) and IFU (1),
// one burst in flight, with an RLAST-vs-ARLEN protocol check.
module riscv_axi_rd_arb import axi4_pkg::*, riscv_pkg::*; #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic      ACLK,
    input  logic      ARESETn,
    input  ar_m [1:0] REQ_AR_M,
    output ar_s [1:0] REQ_AR_S,
    input  r_m  [1:0] REQ_R_M,
    output r_s  [1:0] REQ_R_S,
    output ar_m       BUS_AR_M,
    input  ar_s       BUS_AR_S,
    output r_m        BUS_R_M,
    input  r_s        BUS_R_S,
    output logic      PROTO_ERR
);
    arb_state_e state_q, state_d;
    ar_m        ar_q;
    logic       grant_q, last_grant_q, win, hs;
    logic [7:0] len_q;
    logic [8:0] beat_q;
    logic [1:0] gnt;

    riscv_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .req        ({REQ_AR_M[1].ARVALID, REQ_AR_M[0].ARVALID}),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    assign win = gnt[REQ_IFU];
    assign hs  = (state_q == DATA) && BUS_R_S.RVALID && REQ_R_M[grant_q].RREADY;

    always_comb begin
        state_d  = state_q;
        REQ_AR_S = '0;
        REQ_R_S  = '0;
        BUS_AR_M = '0;
        BUS_R_M  = '0;
        case (state_q)
            IDLE: begin
                // ARREADY is combinational, so gate it to keep outputs quiet under reset
                REQ_AR_S[0].ARREADY = ARESETn & gnt[0];
                REQ_AR_S[1].ARREADY = ARESETn & gnt[1];
                if (|gnt) state_d = ADDR;
            end
            ADDR: begin
                BUS_AR_M         = ar_q;
                BUS_AR_M.ARVALID = 1'b1;
                if (BUS_AR_S.ARREADY) state_d = DATA;
            end
            DATA: begin
                REQ_R_S[grant_q] = BUS_R_S;
                BUS_R_M.RREADY   = REQ_R_M[grant_q].RREADY;
                if (hs && BUS_R_S.RLAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            ar_q         <= '0;
            grant_q      <= 1'b0;
            len_q        <= '0;
            beat_q       <= '0;
            last_grant_q <= 1'b1;
            PROTO_ERR    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |gnt) begin
                ar_q         <= REQ_AR_M[win];
                grant_q      <= win;
                len_q        <= REQ_AR_M[win].ARLEN;
                last_grant_q <= win;
            end
            if (hs) begin
                beat_q <= BUS_R_S.RLAST ? 9'd0 : beat_q + 9'd1;
                // RLAST must land exactly on beat ARLEN; both early and late RLAST are errors
                if (BUS_R_S.RLAST ? (beat_q != {1'b0, len_q}) : (beat_q == {1'b0, len_q}))
                    PROTO_ERR <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_riscv_axi_rd_arb.sv
// tb_riscv_axi_rd_arb: randomized bursts checked against a transaction-level model of
// grant order, address capture, R routing and the sticky protocol-error flag.
module tb_riscv_axi_rd_arb;
    import axi4_pkg::*;

    logic      clk, rst_n;
    ar_m [1:0] req_ar_m, fp_req_ar_m;
    ar_s [1:0] req_ar_s, fp_req_ar_s;
    r_m  [1:0] req_r_m, fp_req_r_m;
    r_s  [1:0] req_r_s, fp_req_r_s;
    ar_m       bus_ar_m, fp_bus_ar_m;
    ar_s       bus_ar_s, fp_bus_ar_s;
    r_m        bus_r_m, fp_bus_r_m;
    r_s        bus_r_s, fp_bus_r_s;
    logic      proto_err, fp_proto_err;

    int   checks = 0;
    int   errors = 0;
    logic m_last, m_err;

    riscv_axi_rd_arb dut (
        .ACLK(clk), .ARESETn(rst_n),
        .REQ_AR_M(req_ar_m), .REQ_AR_S(req_ar_s), .REQ_R_M(req_r_m), .REQ_R_S(req_r_s),
        .BUS_AR_M(bus_ar_m), .BUS_AR_S(bus_ar_s), .BUS_R_M(bus_r_m), .BUS_R_S(bus_r_s),
        .PROTO_ERR(proto_err)
    );

    riscv_axi_rd_arb #(.FIXED_PRIO(1'b1)) dut_fp (
        .ACLK(clk), .ARESETn(rst_n),
        .REQ_AR_M(fp_req_ar_m), .REQ_AR_S(fp_req_ar_s), .REQ_R_M(fp_req_r_m), .REQ_R_S(fp_req_r_s),
        .BUS_AR_M(fp_bus_ar_m), .BUS_AR_S(fp_bus_ar_s), .BUS_R_M(fp_bus_r_m), .BUS_R_S(fp_bus_r_s),
        .PROTO_ERR(fp_proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic ar_m mk_ar(input logic v, input logic [7:0] l);
        ar_m a;
        a.ARVALID = v;
        a.ARADDR  = $urandom;
        a.ARLEN   = l;
        a.ARSIZE  = 3'($urandom);
        a.ARBURST = 2'($urandom);
        a.ARID    = 4'($urandom);
        return a;
    endfunction

    // Async reset held one cycle with busy inputs: every output must drop immediately.
    task automatic do_reset;
        req_ar_m[0].ARVALID = 1'b1;
        req_ar_m[1].ARVALID = 1'b1;
        bus_r_s.RVALID = 1'b1;
        req_r_m = '1;
        rst_n = 1'b0;
        #1;
        check("rst_outputs", 64'(|{req_ar_s, req_r_s, bus_ar_m, bus_r_m, proto_err}), 0);
        check("rst_err", proto_err, 0);
        tick;
        check("rst_hold", 64'(|{req_ar_s, req_r_s, bus_ar_m, bus_r_m, proto_err}), 0);
        req_ar_m = '0;
        bus_r_s  = '0;
        req_r_m  = '0;
        bus_ar_s = '0;
        rst_n    = 1'b1;
        m_last   = 1'b1;
        m_err    = 1'b0;
    endtask

    // One burst from IDLE. rl_at: beat index carrying RLAST (-1 = the correct one);
    // rst_at: handshake count at which reset is pulsed mid-burst (-1 = never).
    task automatic burst(input logic [1:0] reqs, input logic [7:0] l0, input logic [7:0] l1,
                         input int rl_at, input int ar_dly, input int rst_at);
        ar_m        p[2];
        int         w, rl, beats, budget;
        logic [7:0] len;
        logic [1:0] eg;
        p[0] = mk_ar(reqs[0], l0);
        p[1] = mk_ar(reqs[1], l1);
        w  = (reqs == 2'b11) ? int'(!m_last) : (reqs[1] ? 1 : 0);
        eg = (w == 1) ? 2'b10 : 2'b01;
        len = (w == 1) ? l1 : l0;
        req_ar_m[0] = p[0];
        req_ar_m[1] = p[1];
        bus_r_s = '0;
        bus_r_s.RVALID = 1'b1;
        req_r_m = '1;
        #1;
        check("arready", {req_ar_s[1].ARREADY, req_ar_s[0].ARREADY}, eg);
        check("idle_quiet", 64'(|{req_r_s, bus_r_m, bus_ar_m}), 0);
        check("err_pre", proto_err, m_err);
        m_last = w[0];
        tick;
        req_ar_m = '0;
        for (int k = 0; k <= ar_dly; k++) begin
            bus_ar_s.ARREADY = (k == ar_dly);
            req_ar_m[w].ARADDR = $urandom;
            #1;
            check("bus_ar", bus_ar_m, p[w]);
            check("addr_quiet", 64'(|{req_ar_s, bus_r_m, req_r_s}), 0);
            tick;
        end
        bus_ar_s = '0;
        rl = (rl_at < 0) ? int'(len) : rl_at;
        beats = 0;
        budget = 0;
        while (beats <= rl && budget < 300) begin
            budget++;
            bus_r_s        = '0;
            bus_r_s.RVALID = ($urandom_range(3) != 0);
            bus_r_s.RDATA  = $urandom;
            bus_r_s.RRESP  = 2'($urandom);
            bus_r_s.RID    = 4'($urandom);
            bus_r_s.RLAST  = (beats == rl);
            req_r_m[0].RREADY = 1'($urandom);
            req_r_m[1].RREADY = 1'($urandom);
            #1;
            check("rready", bus_r_m.RREADY, req_r_m[w].RREADY);
            check("r_route", req_r_s[w], bus_r_s);
            check("r_other", req_r_s[1-w], 0);
            if (beats == rst_at) begin
                do_reset;
                return;
            end
            if (bus_r_s.RVALID && req_r_m[w].RREADY) beats++;
            tick;
        end
        if (budget >= 300) check("r_timeout", 1, 0);
        bus_r_s = '0;
        req_r_m = '0;
        if (rl != int'(len)) m_err = 1'b1;
        check("proto_err", proto_err, m_err);
    endtask

    initial begin
        int         n;
        logic [1:0] r;
        clk = 1'b0;
        rst_n = 1'b0;
        req_ar_m = '0; req_r_m = '0; bus_ar_s = '0; bus_r_s = '0;
        fp_req_ar_m = '0; fp_req_r_m = '0; fp_bus_ar_s = '0; fp_bus_r_s = '0;
        m_last = 1'b1;
        m_err = 1'b0;
        do_reset;
        burst(2'b10, 8'd0, 8'd0, -1, 0, -1);
        for (int i = 0; i < 4; i++) burst(2'b11, 8'd0, 8'd0, -1, 0, -1);
        burst(2'b01, 8'd2, 8'd2, -1, 5, -1);
        burst(2'b10, 8'd3, 8'd3, -1, 1, -1);
        burst(2'b01, 8'd3, 8'd3, -1, 0, 2);
        check("post_rst_err", proto_err, 0);
        burst(2'b10, 8'd3, 8'd3, 1, 0, -1);
        burst(2'b11, 8'd1, 8'd0, -1, 2, -1);
        do_reset;
        burst(2'b01, 8'd0, 8'd0, 1, 0, -1);
        do_reset;
        for (int i = 0; i < 150; i++) begin
            r = 2'($urandom_range(3, 1));
            burst(r, 8'($urandom_range(4)), 8'($urandom_range(4)),
                  ($urandom_range(9) == 0) ? int'($urandom_range(5)) : -1,
                  int'($urandom_range(3)), -1);
        end
        // IFU-priority instance: both always requesting, single-beat bursts back to back
        fp_req_ar_m[0] = mk_ar(1'b1, 8'd0);
        fp_req_ar_m[1] = mk_ar(1'b1, 8'd0);
        fp_bus_ar_s.ARREADY = 1'b1;
        fp_bus_r_s.RVALID = 1'b1;
        fp_bus_r_s.RLAST = 1'b1;
        fp_req_r_m = '1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (|{fp_req_ar_s[1].ARREADY, fp_req_ar_s[0].ARREADY}) begin
                n++;
                check("fp_grant", {fp_req_ar_s[1].ARREADY, fp_req_ar_s[0].ARREADY}, 2'b10);
            end
            tick;
        end
        check("fp_count", n, 4);
        check("fp_err", fp_proto_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
